// File: rtl/run_ctrl_if.sv
// run_ctrl_if -- signal bundle between the run/halt/step controller and the
// core/debugger side.
//   master : core controller + debugger + data memory (drives requests, hlt,
//            step count, debugger address and memory read data)
//   slave  : run_ctrl (drives core_en, halted, memory port select/address,
//            read ack/data and the retired-instruction count)
interface run_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  // requests / core status
  logic              hlt;
  logic              halt_req;
  logic              resume_req;
  logic              step_req;
  logic [7:0]        step_cnt;
  logic              dbg_rd_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] mem_rdata;
  // controller outputs
  logic              core_en;
  logic              halted;
  logic              mem_dbg_sel;
  logic [ADDR_W-3:0] mem_dbg_addr;
  logic              dbg_rd_ack;
  logic [DATA_W-1:0] dbg_rdata;
  logic [31:0]       instret;

  modport master (
    output hlt, halt_req, resume_req, step_req, step_cnt,
           dbg_rd_req, dbg_addr, mem_rdata,
    input  core_en, halted, mem_dbg_sel, mem_dbg_addr,
           dbg_rd_ack, dbg_rdata, instret
  );

  modport slave (
    input  hlt, halt_req, resume_req, step_req, step_cnt,
           dbg_rd_req, dbg_addr, mem_rdata,
    output core_en, halted, mem_dbg_sel, mem_dbg_addr,
           dbg_rd_ack, dbg_rdata, instret
  );
endinterface

// File: rtl/run_ctrl.sv
// run_ctrl -- run/halt/step controller and data-memory debug-port arbiter for
// the single-cycle RV32I core.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : run_ctrl_if.slave -- requests in; core_en, halted, debug memory
//          port select/address, read ack/data and instret out
// The core runs out of reset. While halted, the debugger can single-step
// N instructions, resume, or read one data-memory word through a one-cycle
// READ state that borrows the memory read port.
module run_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input logic       clk,
  input logic       rst,
  run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STEP   = 2'd1,
    ST_HALTED = 2'd2,
    ST_READ   = 2'd3
  } state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic              w_rd_accept;
  logic              w_step_accept;
  logic              w_core_en;
  logic              w_halted;
  logic              w_mem_dbg_sel;
  logic              w_stop;

  logic [31:0]       r_instret;
  logic [7:0]        r_remaining;
  logic [ADDR_W-3:0] r_addr_q;
  logic              r_ack;
  logic [DATA_W-1:0] r_rdata;

  // Only the word index of the debugger address is used.
  logic              w_unused_addr_lsb;
  assign w_unused_addr_lsb = &{1'b0, bus.dbg_addr[1:0]};

  // A halt decode or halt request stops the core in the same cycle.
  assign w_stop = bus.hlt | bus.halt_req;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_RUN;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_rd_accept   = 1'b0;
    w_step_accept = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        if (w_stop) w_state_nxt = ST_HALTED;
      end
      ST_STEP: begin
        // Interrupted, or this is the last instruction of the burst.
        if (w_stop || r_remaining == 8'd1) w_state_nxt = ST_HALTED;
      end
      ST_HALTED: begin
        // The ack cycle is a dead cycle so a requester that drops its
        // request on ack is not served twice.
        if (!r_ack) begin
          if (bus.dbg_rd_req) begin
            w_state_nxt = ST_READ;
            w_rd_accept = 1'b1;
          end else if (bus.step_req && bus.step_cnt != 8'd0 && !bus.hlt) begin
            w_state_nxt   = ST_STEP;
            w_step_accept = 1'b1;
          end else if (bus.resume_req && !bus.hlt) begin
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_READ: begin
        w_state_nxt = ST_HALTED;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Output logic.
  always_comb begin
    w_core_en     = 1'b0;
    w_halted      = 1'b0;
    w_mem_dbg_sel = 1'b0;
    unique case (r_state)
      ST_RUN, ST_STEP: w_core_en     = !w_stop;
      ST_HALTED:       w_halted      = 1'b1;
      ST_READ: begin
        w_halted      = 1'b1;
        w_mem_dbg_sel = 1'b1;
      end
      default: ;
    endcase
  end

  // Counters, captured address and read-data registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instret   <= '0;
      r_remaining <= '0;
      r_addr_q    <= '0;
      r_ack       <= 1'b0;
      r_rdata     <= '0;
    end else begin
      if (w_core_en) r_instret <= r_instret + 32'd1;

      if (w_step_accept)                       r_remaining <= bus.step_cnt;
      else if (r_state == ST_STEP && w_core_en) r_remaining <= r_remaining - 8'd1;

      if (w_rd_accept) r_addr_q <= bus.dbg_addr[ADDR_W-1:2];

      r_ack <= (r_state == ST_READ);
      if (r_state == ST_READ) r_rdata <= bus.mem_rdata;
    end
  end

  assign bus.core_en      = w_core_en;
  assign bus.halted       = w_halted;
  assign bus.mem_dbg_sel  = w_mem_dbg_sel;
  assign bus.mem_dbg_addr = r_addr_q;
  assign bus.dbg_rd_ack   = r_ack;
  assign bus.dbg_rdata    = r_rdata;
  assign bus.instret      = r_instret;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl -- self-checking bench for run_ctrl. A small data memory model
// answers the debug read port; expected instret / step / read results are
// tracked arithmetically in the bench.
module tb_run_ctrl;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [31:0] m_instret;         // expected retired-instruction count
  logic [31:0] mem [64];          // data memory model (word indexed)

  run_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  run_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.mem_rdata = mem[bus.mem_dbg_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.hlt        = 1'b0;
    bus.halt_req   = 1'b0;
    bus.resume_req = 1'b0;
    bus.step_req   = 1'b0;
    bus.step_cnt   = 8'd0;
    bus.dbg_rd_req = 1'b0;
    bus.dbg_addr   = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    m_instret = 32'd0;
  endtask

  task automatic go_halted();
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    n_checks++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL go_halted: halted=%0b want 1", bus.halted); end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    #2;
    n_checks++; if (bus.core_en !== 1'b1)     begin n_fail++; $display("FAIL reset_core_en: got %0b want 1", bus.core_en); end
    n_checks++; if (bus.halted !== 1'b0)      begin n_fail++; $display("FAIL reset_halted: got %0b want 0", bus.halted); end
    n_checks++; if (bus.mem_dbg_sel !== 1'b0) begin n_fail++; $display("FAIL reset_sel: got %0b want 0", bus.mem_dbg_sel); end
    n_checks++; if (bus.mem_dbg_addr !== '0)  begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus.mem_dbg_addr); end
    n_checks++; if (bus.dbg_rd_ack !== 1'b0)  begin n_fail++; $display("FAIL reset_ack: got %0b want 0", bus.dbg_rd_ack); end
    n_checks++; if (bus.dbg_rdata !== '0)     begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.dbg_rdata); end
    n_checks++; if (bus.instret !== 32'd0)    begin n_fail++; $display("FAIL reset_instret: got %0d want 0", bus.instret); end
    tick();
    rst = 1'b1;
    m_instret = 32'd0;
    repeat (10) begin tick(); m_instret = m_instret + 32'd1; end
    n_checks++; if (bus.instret !== m_instret) begin n_fail++; $display("FAIL run10_instret: got %0d want %0d", bus.instret, m_instret); end
    n_checks++; if (bus.core_en !== 1'b1)      begin n_fail++; $display("FAIL run10_core_en: got %0b want 1", bus.core_en); end
    n_checks++; if (bus.halted !== 1'b0)       begin n_fail++; $display("FAIL run10_halted: got %0b want 0", bus.halted); end
  endtask

  task automatic test_halt_resume();
    apply_reset();
    repeat (5) begin tick(); m_instret = m_instret + 32'd1; end
    bus.halt_req = 1'b1;
    #1;
    n_checks++; if (bus.core_en !== 1'b0) begin n_fail++; $display("FAIL halt_core_en_same_cycle: got %0b want 0", bus.core_en); end
    n_checks++; if (bus.halted !== 1'b0)  begin n_fail++; $display("FAIL halt_halted_same_cycle: got %0b want 0", bus.halted); end
    tick();
    bus.halt_req = 1'b0;
    n_checks++; if (bus.halted !== 1'b1)       begin n_fail++; $display("FAIL halt_halted_next: got %0b want 1", bus.halted); end
    n_checks++; if (bus.instret !== m_instret) begin n_fail++; $display("FAIL halt_instret: got %0d want %0d", bus.instret, m_instret); end
    repeat (3) tick();
    n_checks++; if (bus.instret !== m_instret) begin n_fail++; $display("FAIL halted_hold_instret: got %0d want %0d", bus.instret, m_instret); end
    n_checks++; if (bus.core_en !== 1'b0)      begin n_fail++; $display("FAIL halted_core_en: got %0b want 0", bus.core_en); end
    bus.resume_req = 1'b1;
    tick();
    bus.resume_req = 1'b0;
    n_checks++; if (bus.halted !== 1'b0 || bus.core_en !== 1'b1) begin n_fail++; $display("FAIL resume: halted=%0b core_en=%0b want 0/1", bus.halted, bus.core_en); end
    repeat (4) begin tick(); m_instret = m_instret + 32'd1; end
    n_checks++; if (bus.instret !== m_instret) begin n_fail++; $display("FAIL resume_instret: got %0d want %0d", bus.instret, m_instret); end
    go_halted();
  endtask

  // Precondition: HALTED. Expect exactly n enabled cycles, then HALTED.
  task automatic test_step(input logic [7:0] n);
    bus.step_req = 1'b1;
    bus.step_cnt = n;
    tick();
    bus.step_req = 1'b0;
    bus.step_cnt = 8'($urandom);
    for (int i = 0; i < int'(n) + 2; i++) begin
      if (i < int'(n)) begin
        n_checks++; if (bus.core_en !== 1'b1 || bus.halted !== 1'b0) begin n_fail++; $display("FAIL step%0d_cyc%0d: core_en=%0b halted=%0b want 1/0", n, i, bus.core_en, bus.halted); end
        m_instret = m_instret + 32'd1;
      end else begin
        n_checks++; if (bus.core_en !== 1'b0 || bus.halted !== 1'b1) begin n_fail++; $display("FAIL step%0d_done%0d: core_en=%0b halted=%0b want 0/1", n, i, bus.core_en, bus.halted); end
      end
      tick();
    end
    n_checks++; if (bus.instret !== m_instret) begin n_fail++; $display("FAIL step%0d_instret: got %0d want %0d", n, bus.instret, m_instret); end
  endtask

  // Precondition: HALTED and no ack pending.
  task automatic test_read(input logic [7:0] addr);
    logic [31:0] exp_word;
    exp_word = mem[addr[7:2]];
    bus.dbg_rd_req = 1'b1;
    bus.dbg_addr   = addr;
    tick();
    n_checks++; if (bus.mem_dbg_sel !== 1'b1 || bus.mem_dbg_addr !== addr[7:2]) begin n_fail++; $display("FAIL read_%h_port: sel=%0b idx=%0d want 1/%0d", addr, bus.mem_dbg_sel, bus.mem_dbg_addr, addr[7:2]); end
    n_checks++; if (bus.dbg_rd_ack !== 1'b0 || bus.halted !== 1'b1) begin n_fail++; $display("FAIL read_%h_early: ack=%0b halted=%0b want 0/1", addr, bus.dbg_rd_ack, bus.halted); end
    tick();
    bus.dbg_rd_req = 1'b0;
    n_checks++; if (bus.dbg_rd_ack !== 1'b1 || bus.mem_dbg_sel !== 1'b0) begin n_fail++; $display("FAIL read_%h_ack: ack=%0b sel=%0b want 1/0", addr, bus.dbg_rd_ack, bus.mem_dbg_sel); end
    n_checks++; if (bus.dbg_rdata !== exp_word) begin n_fail++; $display("FAIL read_%h_data: got %h want %h", addr, bus.dbg_rdata, exp_word); end
    tick();
    n_checks++; if (bus.dbg_rd_ack !== 1'b0 || bus.dbg_rdata !== exp_word) begin n_fail++; $display("FAIL read_%h_after: ack=%0b data=%h want 0/%h", addr, bus.dbg_rd_ack, bus.dbg_rdata, exp_word); end
  endtask

  task automatic test_random();
    logic [7:0] a;
    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 1) == 0) begin
        test_step(8'($urandom_range(0, 9)));
      end else begin
        a = 8'($urandom);
        mem[a[7:2]] = $urandom;
        test_read(a);
      end
    end
  endtask

  // Request held through the ack: re-served after one dead cycle.
  task automatic test_back_to_back();
    logic [31:0] w;
    w = $urandom;
    mem[13] = w;
    bus.dbg_rd_req = 1'b1;
    bus.dbg_addr   = 8'h37;
    tick();
    n_checks++; if (bus.mem_dbg_sel !== 1'b1) begin n_fail++; $display("FAIL b2b_first_sel: got %0b want 1", bus.mem_dbg_sel); end
    tick();
    n_checks++; if (bus.dbg_rd_ack !== 1'b1 || bus.dbg_rdata !== w || bus.mem_dbg_sel !== 1'b0) begin n_fail++; $display("FAIL b2b_first_ack: ack=%0b data=%h sel=%0b want 1/%h/0", bus.dbg_rd_ack, bus.dbg_rdata, bus.mem_dbg_sel, w); end
    tick();
    n_checks++; if (bus.mem_dbg_sel !== 1'b0 || bus.dbg_rd_ack !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: sel=%0b ack=%0b want 0/0", bus.mem_dbg_sel, bus.dbg_rd_ack); end
    tick();
    bus.dbg_rd_req = 1'b0;
    n_checks++; if (bus.mem_dbg_sel !== 1'b1) begin n_fail++; $display("FAIL b2b_second_sel: got %0b want 1", bus.mem_dbg_sel); end
    tick();
    n_checks++; if (bus.dbg_rd_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_second_ack: got %0b want 1", bus.dbg_rd_ack); end
    tick();
    n_checks++; if (bus.dbg_rd_ack !== 1'b0 || bus.mem_dbg_sel !== 1'b0) begin n_fail++; $display("FAIL b2b_end: ack=%0b sel=%0b want 0/0", bus.dbg_rd_ack, bus.mem_dbg_sel); end
  endtask

  task automatic test_hlt_terminal();
    apply_reset();
    repeat (2) begin tick(); m_instret = m_instret + 32'd1; end
    bus.hlt = 1'b1;
    #1;
    n_checks++; if (bus.core_en !== 1'b0) begin n_fail++; $display("FAIL hlt_core_en: got %0b want 0", bus.core_en); end
    tick();
    n_checks++; if (bus.halted !== 1'b1 || bus.instret !== m_instret) begin n_fail++; $display("FAIL hlt_halted: halted=%0b instret=%0d want 1/%0d", bus.halted, bus.instret, m_instret); end
    bus.resume_req = 1'b1;
    tick();
    tick();
    bus.resume_req = 1'b0;
    n_checks++; if (bus.halted !== 1'b1 || bus.core_en !== 1'b0) begin n_fail++; $display("FAIL hlt_resume_ignored: halted=%0b core_en=%0b want 1/0", bus.halted, bus.core_en); end
    bus.step_req = 1'b1;
    bus.step_cnt = 8'd3;
    tick();
    tick();
    bus.step_req = 1'b0;
    n_checks++; if (bus.halted !== 1'b1 || bus.core_en !== 1'b0 || bus.instret !== m_instret) begin n_fail++; $display("FAIL hlt_step_ignored: halted=%0b core_en=%0b instret=%0d want 1/0/%0d", bus.halted, bus.core_en, bus.instret, m_instret); end
    mem[21] = $urandom;
    test_read(8'h56);
    bus.hlt = 1'b0;
  endtask

  task automatic test_pending_read();
    logic [31:0] w;
    apply_reset();
    w = $urandom;
    mem[9] = w;
    bus.dbg_rd_req = 1'b1;
    bus.dbg_addr   = 8'h24;
    repeat (3) begin
      tick();
      m_instret = m_instret + 32'd1;
      n_checks++; if (bus.mem_dbg_sel !== 1'b0 || bus.dbg_rd_ack !== 1'b0 || bus.core_en !== 1'b1) begin n_fail++; $display("FAIL pend_run: sel=%0b ack=%0b core_en=%0b want 0/0/1", bus.mem_dbg_sel, bus.dbg_rd_ack, bus.core_en); end
    end
    n_checks++; if (bus.instret !== m_instret) begin n_fail++; $display("FAIL pend_instret: got %0d want %0d", bus.instret, m_instret); end
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    n_checks++; if (bus.halted !== 1'b1 || bus.mem_dbg_sel !== 1'b0) begin n_fail++; $display("FAIL pend_halted: halted=%0b sel=%0b want 1/0", bus.halted, bus.mem_dbg_sel); end
    tick();
    n_checks++; if (bus.mem_dbg_sel !== 1'b1 || bus.mem_dbg_addr !== 6'd9) begin n_fail++; $display("FAIL pend_sel: sel=%0b idx=%0d want 1/9", bus.mem_dbg_sel, bus.mem_dbg_addr); end
    tick();
    bus.dbg_rd_req = 1'b0;
    n_checks++; if (bus.dbg_rd_ack !== 1'b1 || bus.dbg_rdata !== w) begin n_fail++; $display("FAIL pend_ack: ack=%0b data=%h want 1/%h", bus.dbg_rd_ack, bus.dbg_rdata, w); end
    tick();
  endtask

  // Precondition: HALTED with a nonzero dbg_rdata from the previous read.
  task automatic test_reset_in_read();
    mem[30] = 32'hA5A5_0001;
    bus.dbg_rd_req = 1'b1;
    bus.dbg_addr   = 8'h78;
    tick();
    n_checks++; if (bus.mem_dbg_sel !== 1'b1) begin n_fail++; $display("FAIL rstrd_in_read: sel=%0b want 1", bus.mem_dbg_sel); end
    rst = 1'b0;
    #1;
    n_checks++; if (bus.mem_dbg_sel !== 1'b0 || bus.mem_dbg_addr !== '0 || bus.halted !== 1'b0) begin n_fail++; $display("FAIL rstrd_port: sel=%0b idx=%0d halted=%0b want 0/0/0", bus.mem_dbg_sel, bus.mem_dbg_addr, bus.halted); end
    n_checks++; if (bus.dbg_rdata !== '0 || bus.instret !== 32'd0) begin n_fail++; $display("FAIL rstrd_regs: data=%h instret=%0d want 0/0", bus.dbg_rdata, bus.instret); end
    tick();
    n_checks++; if (bus.dbg_rd_ack !== 1'b0 || bus.core_en !== 1'b1) begin n_fail++; $display("FAIL rstrd_ack: ack=%0b core_en=%0b want 0/1", bus.dbg_rd_ack, bus.core_en); end
    bus.dbg_rd_req = 1'b0;
    rst = 1'b1;
    m_instret = 32'd0;
  endtask

  task automatic test_wrap();
    tick();
    force dut.r_instret = 32'hFFFF_FFFF;
    #1;
    release dut.r_instret;
    n_checks++; if (bus.instret !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preset: got %h want ffffffff", bus.instret); end
    m_instret = 32'hFFFF_FFFF;
    tick();
    m_instret = m_instret + 32'd1;
    n_checks++; if (bus.instret !== m_instret) begin n_fail++; $display("FAIL wrap_zero: got %h want %h", bus.instret, m_instret); end
    tick();
    m_instret = m_instret + 32'd1;
    n_checks++; if (bus.instret !== m_instret) begin n_fail++; $display("FAIL wrap_one: got %h want %h", bus.instret, m_instret); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[4] = 32'hDEAD_BEEF;

    test_reset();
    test_halt_resume();
    test_step(8'd3);
    test_step(8'd0);
    test_read(8'h10);
    test_random();
    test_back_to_back();
    test_hlt_terminal();
    test_pending_read();
    go_halted();
    test_read(8'h40);
    test_reset_in_read();
    test_wrap();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Run/halt/step controller and data-memory debug-port arbiter for the single-cycle RV32I core. It generates the datapath clock enable from the controller's `hlt` decode and from debugger requests. It counts retired instructions and runs N-instruction single-step bursts. While the core is halted, it gives the data-memory read port to a debugger, providing a handshaked, registered word readout.

## Interface
- `ADDR_W`, default 8: debugger byte-address width.
- `DATA_W`, default 32: data-memory word width.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `hlt`  in  1  halt-instruction decode from the controller for the current instruction.
- `halt_req`  in  1  debugger halt request, level.
- `resume_req`  in  1  debugger resume request, level.
- `step_req`  in  1  debugger step request, level.
- `step_cnt`  in  8  number of instructions to execute on a step.
- `dbg_rd_req`  in  1  debugger memory read request, level, held until ack.
- `dbg_addr`  in  ADDR_W  debugger byte address.
- `mem_rdata`  in  DATA_W  data-memory read data; combinational from `mem_dbg_addr`.
- `core_en`  out  1  datapath clock enable; the core advances one instruction per cycle with `core_en`=1.
- `halted`  out  1  1 in HALTED and READ.
- `mem_dbg_sel`  out  1  1 gives the data-memory read port to the debugger.
- `mem_dbg_addr`  out  ADDR_W-2  word index, equal to `dbg_addr[ADDR_W-1:2]`.
- `dbg_rd_ack`  out  1  one-cycle pulse; `dbg_rdata` is valid.
- `dbg_rdata`  out  DATA_W  captured memory word.
- `instret`  out  32  count of retired instructions.

## Operation
- The state machine has four states: RUN, STEP, HALTED, READ. Reset state is RUN, so the core executes out of reset.
- `core_en` is combinational: 1 only when state is RUN or STEP, `hlt`=0 and `halt_req`=0.
- `instret` increments on every cycle with `core_en`=1. It wraps from 0xFFFFFFFF to 0.
- RUN behaviour:
  - `hlt`=1 or `halt_req`=1 moves the state to HALTED.
  - The instruction present in that cycle is not retired.
- HALTED behaviour:
  - Requests are accepted with priority `dbg_rd_req` > `step_req` > `resume_req`.
  - `dbg_rd_req`: latch `dbg_addr` into `addr_q` and go to READ.
  - `step_req` with `step_cnt`≠0 and `hlt`=0: load `remaining`=`step_cnt` and go to STEP.
  - `step_req` with `step_cnt`=0 is ignored.
  - `resume_req` with `hlt`=0: go to RUN.
  - While `hlt`=1, step and resume are ignored, because a halt instruction is terminal until reset.
  - No new request is accepted in a cycle where `dbg_rd_ack`=1.
- STEP behaviour:
  - Each cycle with `core_en`=1 decrements `remaining`.
  - In the cycle `core_en`=1 and `remaining`=1, go to HALTED.
  - `hlt`=1 or `halt_req`=1 goes to HALTED immediately, without retiring.
- READ behaviour:
  - READ lasts exactly one cycle.
  - `mem_dbg_sel`=1 and `mem_dbg_addr`=`addr_q[ADDR_W-1:2]`.
  - `mem_rdata` is registered into `dbg_rdata`, then the state returns to HALTED.
- `dbg_rd_req` asserted in RUN or STEP is held pending. It is serviced after the core reaches HALTED.
- `mem_dbg_sel`=0 in every state except READ. The core owns the port then.

## Timing
- Reset values:
  - state RUN
  - `core_en` follows the RUN state (1 if `hlt`=0)
  - `halted`=0
  - `mem_dbg_sel`=0, `mem_dbg_addr`=0
  - `dbg_rd_ack`=0, `dbg_rdata`=0
  - `instret`=0
  - `remaining`=0, `addr_q`=0
- Reset asserted mid-STEP or mid-READ aborts the operation. No ack is produced.
- Halt latency: `core_en` drops in the same cycle `hlt` or `halt_req` rises. `halted` rises on the next edge.
- Step latency: `step_req` is sampled at edge t. `core_en`=1 for exactly `step_cnt` cycles starting at t+1, unless interrupted. `halted` rises the edge after the last enabled cycle.
- Read latency: `dbg_rd_req` is sampled in HALTED at edge t. READ runs during cycle t+1. `dbg_rd_ack`=1 and `dbg_rdata` are valid during cycle t+2, for one cycle only.
- Requester handshake: drop `dbg_rd_req` in the ack cycle, or the request is re-serviced one cycle later.
- `dbg_rdata` holds its value until the next READ.

## Test plan
- Reset release with `hlt`=0 for 10 cycles -> `core_en`=1, `instret`=10, `halted`=0.
- `halt_req` pulse at cycle 5 after reset -> `core_en`=0 that cycle, `instret`=5, `halted`=1 from cycle 6. Then `resume_req` -> RUN, counting resumes.
- HALTED, `step_req` with `step_cnt`=3 -> exactly 3 enabled cycles, `instret`+3, back to HALTED. `step_cnt`=0 -> no change.
- HALTED, word index 4 preloaded with 0xDEADBEEF, `dbg_rd_req` with `dbg_addr`=0x10 -> `mem_dbg_sel`=1 for one cycle with `mem_dbg_addr`=4. Then `dbg_rd_ack`=1 and `dbg_rdata`=0xDEADBEEF two cycles after sampling.
- `hlt`=1 in RUN, then `resume_req` and `step_req` -> remains HALTED, `core_en`=0. `dbg_rd_req` still served.
- `dbg_rd_req` raised in RUN, then `halt_req` -> read served only after HALTED. `rst` low during READ -> no ack, all outputs at reset values. `instret` preset to 0xFFFFFFFF plus one retire -> 0.
